// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, state encoding and element indexing for the 2x2 matrix stream multiplier
package mat_pkg;

    localparam int MAT_N        = 2;
    localparam int MAT_ELEMS    = MAT_N * MAT_N;
    localparam int MAT_IN_BYTES = 2 * MAT_ELEMS;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SEND    = 2'd2
    } mat_state_t;

    // Slot 0 is the element that lands in the MSBs of a packed matrix.
    function automatic logic [1:0] elem_idx(input logic row, input logic col);
        return {row, col};
    endfunction

endpackage

// File: rtl/mat_mac.sv
// rtl/mat_mac.sv - combinational multiply-accumulate, all arithmetic modulo 2^DW
module mat_mac #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_acc,
    output logic [DW-1:0] o_acc
);

    logic [DW-1:0] w_prod;

    assign w_prod = i_a * i_b;
    assign o_acc  = i_acc + w_prod;

endmodule

// File: rtl/mat_stream_mul.sv
// rtl/mat_stream_mul.sv - byte-stream loader, sequential 2x2 matrix multiply and byte-stream result sender
module mat_stream_mul
    import mat_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            busy,
    output logic [4*DW-1:0] a_flat,
    output logic [4*DW-1:0] b_flat
);

    mat_state_t    r_state;
    logic [DW-1:0] r_a [MAT_ELEMS];
    logic [DW-1:0] r_b [MAT_ELEMS];
    logic [DW-1:0] r_r [MAT_ELEMS];
    logic [2:0]    r_in_cnt;
    logic [1:0]    r_out_cnt;
    logic [2:0]    r_step;
    logic          r_s_ready;
    logic          r_m_valid;
    logic [DW-1:0] r_m_data;
    logic          r_busy;

    logic          w_i, w_j, w_k;
    logic [DW-1:0] w_acc;
    logic          w_s_fire;
    logic          w_m_fire;

    // Step counter bits are {i, j, k}, so k advances fastest and i slowest.
    assign w_i = r_step[2];
    assign w_j = r_step[1];
    assign w_k = r_step[0];

    assign w_s_fire = s_valid && r_s_ready;
    assign w_m_fire = r_m_valid && m_ready;

    mat_mac #(.DW(DW)) u_mac (
        .i_a   (r_a[elem_idx(w_i, w_k)]),
        .i_b   (r_b[elem_idx(w_k, w_j)]),
        .i_acc (r_r[elem_idx(w_i, w_j)]),
        .o_acc (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_LOAD;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_step    <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_busy    <= 1'b0;
            for (int n = 0; n < MAT_ELEMS; n++) begin
                r_a[n] <= '0;
                r_b[n] <= '0;
                r_r[n] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_s_fire) begin
                        if (r_in_cnt[2])
                            r_b[r_in_cnt[1:0]] <= s_data;
                        else
                            r_a[r_in_cnt[1:0]] <= s_data;
                        if (r_in_cnt == 3'(MAT_IN_BYTES - 1)) begin
                            r_in_cnt  <= '0;
                            r_step    <= '0;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_COMPUTE;
                            for (int n = 0; n < MAT_ELEMS; n++)
                                r_r[n] <= '0;
                        end else begin
                            r_in_cnt <= r_in_cnt + 3'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_r[elem_idx(w_i, w_j)] <= w_acc;
                    r_step <= r_step + 3'd1;
                    // R00 was finished on step 1, so it can be presented as the last step retires.
                    if (r_step == 3'd7) begin
                        r_state   <= ST_SEND;
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_r[0];
                    end
                end
                ST_SEND: begin
                    if (w_m_fire) begin
                        if (r_out_cnt == 2'd3) begin
                            r_out_cnt <= '0;
                            r_m_valid <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_LOAD;
                        end else begin
                            r_out_cnt <= r_out_cnt + 2'd1;
                            r_m_data  <= r_r[r_out_cnt + 2'd1];
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign busy    = r_busy;
    assign a_flat  = {r_a[0], r_a[1], r_a[2], r_a[3]};
    assign b_flat  = {r_b[0], r_b[1], r_b[2], r_b[3]};

endmodule

// File: doc/mat_stream_mul.md
Name: mat_stream_mul

Overview:
- Byte-serial front end plus sequential compute engine for 2x2 matrix multiplication, R = A x B.
- Element format and packing order match the team's combinational packed-32-bit multiplier.
- Accepts the 8 elements of A and B over a valid/ready byte stream.
- Computes R with one multiply-accumulate per cycle, then streams the 4 elements of R out over a valid/ready byte stream.
- Sits between a byte-oriented host link (UART/SPI bridge) and the matrix datapath.

Parameters:
- DW, 8, element width in bits; all arithmetic is modulo 2^DW.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_data  in  DW  input element byte
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  DW  output element of R
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- busy  out  1  high in COMPUTE or SEND
- a_flat  out  4*DW  packed A as {A00,A01,A10,A11}, A00 in MSBs; holds the last loaded value
- b_flat  out  4*DW  packed B, same ordering

Behaviour:
- Reset (async assert, sync release): state=LOAD, in_cnt=0, out_cnt=0, s_ready=1, m_valid=0, m_data=0, busy=0, a_flat=0, b_flat=0, R=0.
- Input order: A00, A01, A10, A11, B00, B01, B10, B11.
- Handshake: a transfer occurs on a rising edge where valid && ready.
- LOAD:
  - s_ready=1.
  - Each accepted byte is stored at index in_cnt, then in_cnt increments.
  - Gaps in s_valid are allowed; in_cnt holds across gaps.
  - On acceptance of the 8th byte: in_cnt returns to 0, R clears to 0, loop indices i=j=k=0, next state COMPUTE.
- COMPUTE:
  - s_ready=0, busy=1.
  - One step per cycle: R[i][j] <= R[i][j] + A[i][k]*B[k][j].
  - Product truncated to DW bits; sum truncated to DW bits.
  - Index order: k fastest, then j, then i. 8 steps total.
  - After the step with i=j=k=1, next state SEND.
- Latency: m_valid rises exactly 8 cycles after the edge that accepted B11.
- SEND:
  - m_valid=1, m_data=R[out_cnt], output order R00, R01, R10, R11.
  - m_data and m_valid hold stable while m_ready=0.
  - On each transfer out_cnt increments.
  - On the 4th transfer: m_valid=0, out_cnt=0, next state LOAD; s_ready=1 on the following cycle.
  - s_valid during COMPUTE or SEND is ignored and the byte is not consumed.
- Reset mid-operation: immediate return to reset values; partial input or output is discarded; no spurious m_valid.
- m_ready is ignored outside SEND; m_valid never asserts outside SEND.

Decomposition:
- Shared package mat_pkg:
  - MAT_N=2, MAT_ELEMS=4, MAT_IN_BYTES=8.
  - State encoding LOAD/COMPUTE/SEND.
  - Element index helper mapping (row,col) to packed position, row*2+col, MSB-first.
- Sub-module mat_mac:
  - Combinational DW-bit multiply-accumulate, acc_out = (acc_in + a*b) mod 2^DW.
  - Instantiated once.
  - Top level holds the FSM, counters, storage and stream handshakes.

Test Plan:
- Basic product: A=[1,2;3,4], B=[5,6;7,8], back-to-back valid, m_ready=1 -> outputs 19, 22, 43, 50; m_valid rises 8 cycles after B11 is accepted; s_ready=1 one cycle after the R11 transfer.
- Identity and packing: A=[1,0;0,1], B=[0x11,0x22;0x33,0x44] -> outputs 0x11, 0x22, 0x33, 0x44; b_flat=0x11223344.
- Wrap-around: all elements 0xFF -> each R element is 0x02 (0xFE01 truncates to 0x01, 0x01+0x01=0x02).
- Flow control: random s_valid gaps and m_ready low for 3 cycles per element -> same results as the basic product; m_data stable while stalled; bytes offered during COMPUTE/SEND are not consumed.
- Reset mid-operation: assert rst_n=0 during COMPUTE step 4, release, then reload the basic-product vectors -> outputs 19, 22, 43, 50; no m_valid before the new load completes.
- Back-to-back: two matrix pairs sent consecutively -> second result is independent of the first (R is cleared between runs).
